// File: rtl/ds_led_msg_sink_pkg.sv
// ds_led_msg_sink_pkg
//   Shared definitions for the LED message sink: header magic, header field
//   positions, FSM state type and a small header decode helper.
package ds_led_msg_sink_pkg;

    // Header word layout (low 32 bits of the sop beat)
    localparam logic [15:0] MAGIC         = 16'hA5C3;
    localparam int          HDR_MAGIC_LSB = 16;
    localparam int          HDR_SEQ_LSB   = 8;
    localparam int          HDR_LED_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] magic;
        logic [7:0]  seq;
        logic [7:0]  led;
    } hdr_t;

    function automatic hdr_t hdr_decode(input logic [31:0] w);
        hdr_t h;
        h.magic = w[HDR_MAGIC_LSB +: 16];
        h.seq   = w[HDR_SEQ_LSB   +: 8];
        h.led   = w[HDR_LED_LSB   +: 8];
        return h;
    endfunction

endpackage

// File: rtl/ds_led_msg_sink_sat_counter.sv
// sat_counter
//   Saturating up-counter. Adds 'inc' each cycle and clamps at all-ones.
//   inc is a small unsigned amount so one cycle can record more than one
//   event (e.g. an abandoned packet and a bad header on the same beat).
// Ports
//   clk    in   1       clock
//   reset  in   1       synchronous, active-high; clears count
//   inc    in   INC_W   amount to add this cycle
//   count  out  W       current count, saturating at all-ones
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    localparam int SW = W + 1;

    // One extra bit catches overflow of the add.
    logic [W:0] sum;
    assign sum = {1'b0, count} + SW'(inc);

    always_ff @(posedge clk) begin
        if (reset)       count <= '0;
        else if (sum[W]) count <= '1;
        else             count <= sum[W-1:0];
    end

endmodule

// File: rtl/ds_led_msg_sink.sv
// ds_led_msg_sink
//   Consumer of a NAP data-stream RX interface. Validates packet framing and
//   the header magic, latches an 8-bit LED value from each good packet, tracks
//   sequence continuity, counts good/bad packets and shows a fixed pattern
//   when messages stop arriving.
// Ports
//   clk            in   1           clock
//   reset          in   1           synchronous, active-high
//   rx_valid       in   1           beat valid
//   rx_ready       out  1           sink ready (1 every cycle out of reset)
//   rx_sop         in   1           first beat of packet
//   rx_eop         in   1           last beat of packet
//   rx_data        in   DATA_WIDTH  beat payload, header in [31:0] on sop
//   rx_addr        in   ADDR_WIDTH  source address
//   leds           out  8           LED value
//   last_src       out  ADDR_WIDTH  rx_addr of last committed packet
//   timed_out      out  1           watchdog expired
//   pkt_count      out  16          good packets, saturating
//   err_count      out  16          framing + header errors, saturating
//   seq_err_count  out  16          sequence discontinuities, saturating
module ds_led_msg_sink
    import ds_led_msg_sink_pkg::*;
#(
    parameter int          DATA_WIDTH      = 256,
    parameter int          ADDR_WIDTH      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100_000_000,
    parameter logic [7:0]  RESET_PATTERN   = 8'h00,
    parameter logic [7:0]  TIMEOUT_PATTERN = 8'hAA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  rx_sop,
    input  logic                  rx_eop,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    output logic [7:0]            leds,
    output logic [ADDR_WIDTH-1:0] last_src,
    output logic                  timed_out,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count,
    output logic [15:0]           seq_err_count
);

    // Watchdog saturates at its trip value; when disabled it simply stays 0.
    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

    state_t                state, nxt_state;
    logic [7:0]            lat_led, lat_seq;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  seq_valid;
    logic [7:0]            expected_seq;
    logic [31:0]           wdog, wd_nxt;

    logic                  accept;
    hdr_t                  hdr;
    logic                  magic_ok;
    logic                  do_commit, do_latch;
    logic                  abandon, hdr_err, frm_err;
    logic [7:0]            c_led, c_seq;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [1:0]            err_inc;
    logic                  seq_inc, pkt_inc;

    assign accept   = rx_valid & rx_ready;
    assign hdr      = hdr_decode(rx_data[31:0]);
    assign magic_ok = (hdr.magic == MAGIC);

    // Payload above the header word carries nothing this sink uses.
    generate
        if (DATA_WIDTH > 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^rx_data[DATA_WIDTH-1:32];
        end
    endgenerate

    // Beat decode. A sop beat is treated identically in every state, apart
    // from the abandon error raised when it cuts short a packet in flight.
    always_comb begin
        nxt_state = state;
        do_commit = 1'b0;
        do_latch  = 1'b0;
        abandon   = 1'b0;
        hdr_err   = 1'b0;
        frm_err   = 1'b0;
        c_led     = lat_led;
        c_seq     = lat_seq;
        c_addr    = lat_addr;
        if (accept) begin
            if (rx_sop) begin
                abandon = (state == IN_PKT);
                if (magic_ok) begin
                    if (rx_eop) begin
                        do_commit = 1'b1;
                        c_led     = hdr.led;
                        c_seq     = hdr.seq;
                        c_addr    = rx_addr;
                        nxt_state = IDLE;
                    end else begin
                        do_latch  = 1'b1;
                        nxt_state = IN_PKT;
                    end
                end else begin
                    hdr_err   = 1'b1;
                    nxt_state = rx_eop ? IDLE : DROP;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        frm_err   = 1'b1;
                        nxt_state = rx_eop ? IDLE : DROP;
                    end
                    IN_PKT: begin
                        if (rx_eop) begin
                            do_commit = 1'b1;
                            nxt_state = IDLE;
                        end
                    end
                    DROP: begin
                        if (rx_eop) nxt_state = IDLE;
                    end
                    default: nxt_state = IDLE;
                endcase
            end
        end
    end

    assign err_inc = {1'b0, abandon} + {1'b0, hdr_err | frm_err};
    assign seq_inc = do_commit & seq_valid & (c_seq != expected_seq);
    assign pkt_inc = do_commit;
    assign wd_nxt  = (wdog == WD_LAST) ? wdog : wdog + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            leds         <= RESET_PATTERN;
            last_src     <= '0;
            timed_out    <= 1'b0;
            seq_valid    <= 1'b0;
            expected_seq <= 8'h00;
            wdog         <= 32'd0;
            lat_led      <= 8'h00;
            lat_seq      <= 8'h00;
            lat_addr     <= '0;
        end else begin
            rx_ready <= 1'b1;
            state    <= nxt_state;
            if (do_latch) begin
                lat_led  <= hdr.led;
                lat_seq  <= hdr.seq;
                lat_addr <= rx_addr;
            end
            // A commit takes priority over a watchdog trip in the same cycle.
            if (do_commit) begin
                leds         <= c_led;
                last_src     <= c_addr;
                timed_out    <= 1'b0;
                wdog         <= 32'd0;
                seq_valid    <= 1'b1;
                expected_seq <= c_seq + 8'd1;
            end else if (TIMEOUT_CYCLES != 32'd0) begin
                wdog <= wd_nxt;
                if (wd_nxt == WD_LAST) begin
                    timed_out <= 1'b1;
                    leds      <= TIMEOUT_PATTERN;
                end
            end
        end
    end

    sat_counter #(.W(16), .INC_W(1)) u_pkt_cnt (
        .clk(clk), .reset(reset), .inc(pkt_inc), .count(pkt_count)
    );

    sat_counter #(.W(16), .INC_W(2)) u_err_cnt (
        .clk(clk), .reset(reset), .inc(err_inc), .count(err_count)
    );

    sat_counter #(.W(16), .INC_W(1)) u_seq_cnt (
        .clk(clk), .reset(reset), .inc(seq_inc), .count(seq_err_count)
    );

endmodule

// File: tb/tb_ds_led_msg_sink.sv
module tb_ds_led_msg_sink;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic [AW-1:0] rx_addr = '0;
    logic          rx_ready;
    logic [7:0]    leds;
    logic [AW-1:0] last_src;
    logic          timed_out;
    logic [15:0]   pkt_count, err_count, seq_err_count;

    logic          sc_reset = 1'b1;
    logic [1:0]    sc_inc = 2'd0;
    logic [2:0]    sc_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ds_led_msg_sink #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(32'd16),
        .RESET_PATTERN(8'h00), .TIMEOUT_PATTERN(8'hAA)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_data(rx_data), .rx_addr(rx_addr),
        .leds(leds), .last_src(last_src), .timed_out(timed_out),
        .pkt_count(pkt_count), .err_count(err_count), .seq_err_count(seq_err_count)
    );

    sat_counter #(.W(3), .INC_W(2)) u_sc (
        .clk(clk), .reset(sc_reset), .inc(sc_inc), .count(sc_count)
    );

    typedef struct {
        logic        v, sop, eop;
        logic [31:0] data;
        logic [7:0]  addr;
        logic [7:0]  e_leds, e_src;
        logic [15:0] e_pkt, e_err, e_serr;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic v, logic s, logic e, logic [31:0] d, logic [7:0] a,
                                logic [7:0] el, logic [7:0] es, logic [15:0] ep,
                                logic [15:0] ee, logic [15:0] esr);
        vec_t r;
        r.v = v; r.sop = s; r.eop = e; r.data = d; r.addr = a;
        r.e_leds = el; r.e_src = es; r.e_pkt = ep; r.e_err = ee; r.e_serr = esr;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic s, logic e, logic [31:0] d, logic [7:0] a);
        rx_valid = v; rx_sop = s; rx_eop = e; rx_data = d; rx_addr = a;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [7:0] el, logic [7:0] es, logic eto,
                           logic [15:0] ep, logic [15:0] ee, logic [15:0] esr);
        chk({tag, " leds"},      32'(leds),          32'(el));
        chk({tag, " last_src"},  32'(last_src),      32'(es));
        chk({tag, " timed_out"}, 32'(timed_out),     32'(eto));
        chk({tag, " pkt"},       32'(pkt_count),     32'(ep));
        chk({tag, " err"},       32'(err_count),     32'(ee));
        chk({tag, " seq_err"},   32'(seq_err_count), 32'(esr));
    endtask

    // Reference model: packet-level view of the stream.
    logic [7:0]  m_leds, m_src, m_hdr_led, m_hdr_seq, m_hdr_src, m_exp_seq;
    logic        m_to, m_seq_valid, m_open, m_discard;
    int          m_pkt, m_err, m_serr, m_idle;

    task automatic model_reset();
        m_leds = 8'h00; m_src = 8'h00; m_to = 1'b0; m_seq_valid = 1'b0; m_exp_seq = 8'h00;
        m_open = 1'b0; m_discard = 1'b0; m_pkt = 0; m_err = 0; m_serr = 0; m_idle = 0;
        m_hdr_led = 8'h00; m_hdr_seq = 8'h00; m_hdr_src = 8'h00;
    endtask

    task automatic model_beat(logic acc, logic s, logic e, logic [31:0] d, logic [7:0] a);
        int errs = 0;
        logic commit = 1'b0;
        logic [7:0] cl = 8'h00, cs = 8'h00, ca = 8'h00;
        if (acc) begin
            if (s) begin
                if (m_open) errs++;
                m_open = 1'b0; m_discard = 1'b0;
                if (d[31:16] == 16'hA5C3) begin
                    if (e) begin commit = 1'b1; cl = d[7:0]; cs = d[15:8]; ca = a; end
                    else begin m_open = 1'b1; m_hdr_led = d[7:0]; m_hdr_seq = d[15:8]; m_hdr_src = a; end
                end else begin
                    errs++;
                    m_discard = !e;
                end
            end else if (m_open) begin
                if (e) begin commit = 1'b1; cl = m_hdr_led; cs = m_hdr_seq; ca = m_hdr_src; m_open = 1'b0; end
            end else if (m_discard) begin
                if (e) m_discard = 1'b0;
            end else begin
                errs++;
                m_discard = !e;
            end
        end
        if (commit) begin
            if (m_seq_valid && cs != m_exp_seq) m_serr = (m_serr < 65535) ? m_serr + 1 : 65535;
            m_seq_valid = 1'b1;
            m_exp_seq = cs + 8'd1;
            m_leds = cl; m_src = ca; m_to = 1'b0; m_idle = 0;
            m_pkt = (m_pkt < 65535) ? m_pkt + 1 : 65535;
        end else begin
            m_idle++;
            if (m_idle >= TO - 1) begin m_to = 1'b1; m_leds = 8'hAA; end
        end
        m_err = (m_err + errs > 65535) ? 65535 : m_err + errs;
    endtask

    initial begin
        int burst;
        logic v, s, e;
        logic [31:0] d;
        logic [1:0]  sc_seq_inc[7];
        logic [2:0]  sc_seq_exp[7];

        //           v  sop eop data            addr   leds   src    pkt    err    serr
        tbl[0]  = mk(0, 0, 0, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 16'd0, 16'd0, 16'd0);
        tbl[1]  = mk(1, 1, 1, 32'hA5C3_0012, 8'h11, 8'h12, 8'h11, 16'd1, 16'd0, 16'd0);
        tbl[2]  = mk(1, 1, 0, 32'hA5C3_013C, 8'h22, 8'h12, 8'h11, 16'd1, 16'd0, 16'd0);
        tbl[3]  = mk(1, 0, 0, 32'h0000_0000, 8'h01, 8'h12, 8'h11, 16'd1, 16'd0, 16'd0);
        tbl[4]  = mk(1, 0, 1, 32'hFFFF_FFFF, 8'h33, 8'h3C, 8'h22, 16'd2, 16'd0, 16'd0);
        tbl[5]  = mk(1, 1, 1, 32'hA5C3_035A, 8'h44, 8'h5A, 8'h44, 16'd3, 16'd0, 16'd1);
        tbl[6]  = mk(1, 1, 1, 32'hA5C3_FF66, 8'h55, 8'h66, 8'h55, 16'd4, 16'd0, 16'd2);
        tbl[7]  = mk(1, 1, 1, 32'hA5C3_0077, 8'h66, 8'h77, 8'h66, 16'd5, 16'd0, 16'd2);
        tbl[8]  = mk(1, 1, 0, 32'h1234_0077, 8'h01, 8'h77, 8'h66, 16'd5, 16'd1, 16'd2);
        tbl[9]  = mk(1, 0, 1, 32'hA5C3_0199, 8'h02, 8'h77, 8'h66, 16'd5, 16'd1, 16'd2);
        tbl[10] = mk(1, 1, 1, 32'hA5C3_0101, 8'h77, 8'h01, 8'h77, 16'd6, 16'd1, 16'd2);
        tbl[11] = mk(1, 1, 0, 32'hA5C3_0244, 8'h88, 8'h01, 8'h77, 16'd6, 16'd1, 16'd2);
        tbl[12] = mk(1, 1, 0, 32'hA5C3_0381, 8'h99, 8'h01, 8'h77, 16'd6, 16'd2, 16'd2);
        tbl[13] = mk(1, 0, 1, 32'h0000_0000, 8'hAA, 8'h81, 8'h99, 16'd7, 16'd2, 16'd3);
        tbl[14] = mk(1, 0, 0, 32'hA5C3_0000, 8'h03, 8'h81, 8'h99, 16'd7, 16'd3, 16'd3);
        tbl[15] = mk(1, 0, 1, 32'h0000_0000, 8'h04, 8'h81, 8'h99, 16'd7, 16'd3, 16'd3);
        tbl[16] = mk(1, 0, 1, 32'hA5C3_0000, 8'h05, 8'h81, 8'h99, 16'd7, 16'd4, 16'd3);
        tbl[17] = mk(0, 1, 1, 32'hA5C3_00EE, 8'h06, 8'h81, 8'h99, 16'd7, 16'd4, 16'd3);
        tbl[18] = mk(1, 1, 0, 32'hA5C3_0410, 8'h07, 8'h81, 8'h99, 16'd7, 16'd4, 16'd3);
        tbl[19] = mk(1, 1, 1, 32'h1234_0000, 8'h08, 8'h81, 8'h99, 16'd7, 16'd6, 16'd3);
        tbl[20] = mk(1, 1, 1, 32'hA5C3_0520, 8'hBB, 8'h20, 8'hBB, 16'd8, 16'd6, 16'd4);

        sc_seq_inc = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
        sc_seq_exp = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

        // Reset state
        step(); step();
        chk("reset rx_ready", 32'(rx_ready), 32'd0);
        chk_all("reset", 8'h00, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0);
        reset = 1'b0; sc_reset = 1'b0;

        // Table of single-cycle beats
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].addr);
            step();
            chk($sformatf("tbl[%0d] ready", i), 32'(rx_ready), 32'd1);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].e_leds, tbl[i].e_src, 1'b0,
                    tbl[i].e_pkt, tbl[i].e_err, tbl[i].e_serr);
        end

        // Watchdog trips 15 cycles after the last commit
        drive(0, 0, 0, 32'h0, 8'h0);
        for (int i = 0; i < 14; i++) step();
        chk_all("wd pre", 8'h20, 8'hBB, 1'b0, 16'd8, 16'd6, 16'd4);
        step();
        chk_all("wd trip", 8'hAA, 8'hBB, 1'b1, 16'd8, 16'd6, 16'd4);
        step();
        chk_all("wd hold", 8'hAA, 8'hBB, 1'b1, 16'd8, 16'd6, 16'd4);
        drive(1, 1, 1, 32'hA5C3_065C, 8'hC1);
        step();
        chk_all("wd clear", 8'h5C, 8'hC1, 1'b0, 16'd9, 16'd6, 16'd4);
        drive(0, 0, 0, 32'h0, 8'h0);
        for (int i = 0; i < 14; i++) step();
        drive(1, 1, 1, 32'hA5C3_0771, 8'hC2);
        step();
        chk_all("wd commit wins", 8'h71, 8'hC2, 1'b0, 16'd10, 16'd6, 16'd4);

        // Reset in the middle of a packet
        drive(1, 1, 0, 32'hA5C3_08E1, 8'hD0); step();
        drive(1, 0, 0, 32'h0, 8'hD0); step();
        reset = 1'b1;
        step();
        chk("midrst ready", 32'(rx_ready), 32'd0);
        chk_all("midrst", 8'h00, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0);
        reset = 1'b0;
        step();
        chk_all("post-rst held", 8'h00, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0);
        step();
        chk_all("post-rst trailing", 8'h00, 8'h00, 1'b0, 16'd0, 16'd1, 16'd0);
        drive(1, 0, 1, 32'h0, 8'hD0); step();
        chk_all("post-rst eop", 8'h00, 8'h00, 1'b0, 16'd0, 16'd1, 16'd0);
        drive(1, 1, 1, 32'hA5C3_4242, 8'hD1); step();
        chk_all("post-rst pkt", 8'h42, 8'hD1, 1'b0, 16'd1, 16'd1, 16'd0);

        // Saturating counter clamps at all-ones, including multi-step adds
        for (int i = 0; i < 7; i++) begin
            sc_inc = sc_seq_inc[i];
            step();
            chk($sformatf("sat[%0d]", i), 32'(sc_count), 32'(sc_seq_exp[i]));
        end
        sc_inc = 2'd0;

        // Randomized traffic against the model
        drive(0, 0, 0, 32'h0, 8'h0);
        reset = 1'b1; step(); step();
        reset = 1'b0;
        model_reset();
        step();
        model_beat(1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (burst > 0) begin
                burst--;
                v = 1'b0;
            end else begin
                if ($urandom_range(99) < 2) burst = $urandom_range(25, 10);
                v = ($urandom_range(3) != 0);
            end
            s = ($urandom_range(2) == 0);
            e = ($urandom_range(2) == 0);
            d[31:16] = ($urandom_range(7) != 0) ? 16'hA5C3 : 16'($urandom);
            d[15:8]  = ($urandom_range(3) != 0) ? m_exp_seq : 8'($urandom);
            d[7:0]   = 8'($urandom);
            drive(v, s, e, d, 8'($urandom));
            model_beat(v, s, e, d, rx_addr);
            step();
            chk($sformatf("rnd[%0d] ready", c), 32'(rx_ready), 32'd1);
            chk_all($sformatf("rnd[%0d]", c), m_leds, m_src, m_to,
                    16'(m_pkt), 16'(m_err), 16'(m_serr));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
